// File: rtl/sector_serializer_pkg.sv
// sector_serializer_pkg: shared types and constants for the sector serializer.
// The CRC state only exists when SECTOR_SERIALIZER_CRC_EN is defined.
package sector_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    PREAMBLE,
    SYNC,
    DATA,
`ifdef SECTOR_SERIALIZER_CRC_EN
    CRC,
`endif
    POSTAMBLE
  } ser_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  localparam int SECTOR_CYCLES = 3906;
  localparam int STROBE_CYCLES = 120;

  // Cycles from the first GAP cycle through the last POSTAMBLE cycle.
  function automatic int frame_cycles(input int gap_bits, input int preamble_bits,
                                      input int data_words, input int postamble_bits,
                                      input bit crc_en);
    return gap_bits + preamble_bits + 1 + 16 * data_words + (crc_en ? 16 : 0) + postamble_bits;
  endfunction

endpackage

// File: rtl/sector_serializer_crc16_serial.sv
// crc16_serial: bit-serial CRC-16/XMODEM (poly 0x1021, init 0, MSB first).
// Only compiled when SECTOR_SERIALIZER_CRC_EN is defined; the serializer
// carries no CRC hardware otherwise.
`ifdef SECTOR_SERIALIZER_CRC_EN
module crc16_serial
  import sector_serializer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_bit_en,
  input  logic        i_bit_in,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_feedback;

  assign w_feedback = r_crc[15] ^ i_bit_in;
  assign o_crc      = r_crc;

  // Clear on frame launch, otherwise fold in one data bit per enabled cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= CRC16_INIT;
    end else if (i_clr) begin
      r_crc <= CRC16_INIT;
    end else if (i_bit_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule
`endif

// File: rtl/sector_serializer.sv
// sector_serializer: emits one sector frame (gap, preamble, sync, data,
// optional CRC, postamble) as NRZ on the 2.5 MHz bit clock, prefetching
// data words one ahead over a request/valid handshake.
// Optional feature macro: SECTOR_SERIALIZER_CRC_EN (appends a CRC-16 field).
module sector_serializer
  import sector_serializer_pkg::*;
#(
  parameter int DATA_WORDS     = 128,
  parameter int GAP_BITS       = 40,
  parameter int PREAMBLE_BITS  = 256,
  parameter int POSTAMBLE_BITS = 16
) (
  input  logic                             i_clk2_5,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic                             i_sector_strobe,
  input  logic [4:0]                       i_sector,
  output logic                             o_word_req,
  output logic [4+$clog2(DATA_WORDS)-1:0]  o_word_addr,
  input  logic [15:0]                      i_word_data,
  input  logic                             i_word_valid,
  output logic                             o_read_data,
  output logic                             o_read_gate,
  output logic                             o_busy,
  output logic                             o_underrun
);

  localparam int IDX_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DATA_WORDS - 1);
`ifdef SECTOR_SERIALIZER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  generate
    if (frame_cycles(GAP_BITS, PREAMBLE_BITS, DATA_WORDS, POSTAMBLE_BITS, CRC_ON)
          > SECTOR_CYCLES - STROBE_CYCLES
        || DATA_WORDS < 1 || DATA_WORDS > 128 || (DATA_WORDS & (DATA_WORDS - 1)) != 0
        || GAP_BITS < 1 || PREAMBLE_BITS < 1 || POSTAMBLE_BITS < 1) begin : g_bad_cfg
      $error("sector_serializer: frame does not fit in a sector or parameters are invalid");
    end
  endgenerate

  ser_state_t       r_state;
  logic             r_strobe_d;
  logic [3:0]       r_sector;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_wcnt;
  logic [11:0]      r_cnt;
  logic [3:0]       r_bit;
  logic [14:0]      r_shift;
  logic [15:0]      r_buf;
  logic             r_buf_full;
  logic             r_pending;
  logic             r_word_req;
  logic             r_read_data;
  logic             r_read_gate;
  logic             r_busy;
  logic             r_underrun;

  logic             w_launch;
  logic             w_abort;
  logic             w_last_bit;
  logic             w_last_word;
  logic             w_word_start;
  logic [IDX_W-1:0] w_next_k;
  logic [15:0]      w_fetch_word;
  logic             w_data_bit;
  logic             w_unused_sector;

  assign w_unused_sector = i_sector[4];

  assign w_launch     = r_strobe_d & ~i_sector_strobe & i_en;
  assign w_abort      = ~i_en | ((r_state != IDLE) & ~r_strobe_d & i_sector_strobe);
  assign w_last_bit   = (r_bit == 4'd15);
  assign w_last_word  = (r_wcnt == LAST_WORD);
  assign w_word_start = (r_state == SYNC) || ((r_state == DATA) && w_last_bit && !w_last_word);
  assign w_next_k     = (r_state == SYNC) ? '0 : r_wcnt + 1'b1;
  assign w_fetch_word = r_buf_full ? r_buf : 16'h0000;
  assign w_data_bit   = w_word_start ? w_fetch_word[15] : r_shift[14];

`ifdef SECTOR_SERIALIZER_CRC_EN
  logic        w_shift_data;
  logic [15:0] w_crc;

  assign w_shift_data = w_word_start || ((r_state == DATA) && !w_last_bit);

  crc16_serial u_crc (
    .i_clk    (i_clk2_5),
    .i_rst    (i_rst),
    .i_clr    (w_launch),
    .i_bit_en (w_shift_data),
    .i_bit_in (w_data_bit),
    .o_crc    (w_crc)
  );
`endif

  generate
    if (DATA_WORDS == 1) begin : g_addr_single
      logic w_unused_idx;
      assign w_unused_idx = ^r_idx;
      assign o_word_addr  = r_sector;
    end else begin : g_addr_multi
      assign o_word_addr = {r_sector, r_idx};
    end
  endgenerate

  assign o_word_req  = r_word_req;
  assign o_read_data = r_read_data;
  assign o_read_gate = r_read_gate;
  assign o_busy      = r_busy;
  assign o_underrun  = r_underrun;

  // Frame sequencer: launch/abort, word prefetch, and registered serial outputs.
  always_ff @(posedge i_clk2_5 or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_strobe_d  <= 1'b0;
      r_sector    <= '0;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_pending   <= 1'b0;
      r_word_req  <= 1'b0;
      r_read_data <= 1'b0;
      r_read_gate <= 1'b0;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_strobe_d <= i_sector_strobe;
      r_word_req <= 1'b0;
      if (w_abort) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_read_data <= 1'b0;
        r_read_gate <= 1'b0;
        r_pending   <= 1'b0;
        r_buf_full  <= 1'b0;
      end else if (w_launch) begin
        r_state     <= GAP;
        r_busy      <= 1'b1;
        r_read_data <= 1'b0;
        r_read_gate <= 1'b0;
        r_sector    <= i_sector[3:0];
        r_idx       <= '0;
        r_wcnt      <= '0;
        r_cnt       <= '0;
        r_word_req  <= 1'b1;
        r_pending   <= 1'b1;
        r_buf_full  <= 1'b0;
      end else begin
        if (r_pending && i_word_valid) begin
          r_buf      <= i_word_data;
          r_buf_full <= 1'b1;
          r_pending  <= 1'b0;
        end
        if (w_word_start) begin
          r_shift    <= w_fetch_word[14:0];
          r_bit      <= '0;
          r_wcnt     <= w_next_k;
          r_buf_full <= 1'b0;
          if (!r_buf_full) begin
            r_underrun <= 1'b1;
          end
          if (w_next_k != LAST_WORD) begin
            r_idx      <= w_next_k + 1'b1;
            r_word_req <= 1'b1;
            r_pending  <= 1'b1;
          end else begin
            r_pending <= 1'b0;
          end
        end
        case (r_state)
          IDLE: begin
          end
          GAP: begin
            if (r_cnt == 12'(GAP_BITS - 1)) begin
              r_state     <= PREAMBLE;
              r_read_gate <= 1'b1;
              r_read_data <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PREAMBLE: begin
            if (r_cnt == 12'(PREAMBLE_BITS - 1)) begin
              r_state     <= SYNC;
              r_read_data <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          SYNC: begin
            r_state     <= DATA;
            r_read_data <= w_data_bit;
          end
          DATA: begin
            if (w_last_bit && w_last_word) begin
`ifdef SECTOR_SERIALIZER_CRC_EN
              r_state     <= CRC;
              r_shift     <= w_crc[14:0];
              r_bit       <= '0;
              r_read_data <= w_crc[15];
`else
              r_state     <= POSTAMBLE;
              r_read_gate <= 1'b0;
              r_read_data <= 1'b0;
              r_cnt       <= '0;
`endif
            end else begin
              r_read_data <= w_data_bit;
              if (!w_last_bit) begin
                r_shift <= {r_shift[13:0], 1'b0};
                r_bit   <= r_bit + 1'b1;
              end
            end
          end
`ifdef SECTOR_SERIALIZER_CRC_EN
          CRC: begin
            if (w_last_bit) begin
              r_state     <= POSTAMBLE;
              r_read_gate <= 1'b0;
              r_read_data <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_read_data <= r_shift[14];
              r_shift     <= {r_shift[13:0], 1'b0};
              r_bit       <= r_bit + 1'b1;
            end
          end
`endif
          POSTAMBLE: begin
            if (r_cnt == 12'(POSTAMBLE_BITS - 1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sector_serializer.sv
// tb_sector_serializer: directed checks of the sector serializer.
// Instance A uses the default geometry; instance B is a one-word sector with
// short gap/preamble/postamble so the data and CRC fields are easy to inspect.
module tb_sector_serializer;

  localparam int HALF = 200;
`ifdef SECTOR_SERIALIZER_CRC_EN
  localparam int CRC_BITS = 16;
`else
  localparam int CRC_BITS = 0;
`endif
  // gap + preamble + sync + data + crc + postamble
  localparam int FRAME_A = 40 + 256 + 1 + 128 * 16 + CRC_BITS + 16;
  localparam int FRAME_B = 4 + 8 + 1 + 16 + CRC_BITS + 4;
  localparam int CAP_N   = 2400;

  logic        clk;
  logic        rst;

  logic        en;
  logic        strobe;
  logic [4:0]  sector;
  logic        word_req;
  logic [10:0] word_addr;
  logic [15:0] word_data;
  logic        word_valid;
  logic        read_data;
  logic        read_gate;
  logic        busy;
  logic        underrun;

  logic        en_b;
  logic        strobe_b;
  logic [4:0]  sector_b;
  logic        word_req_b;
  logic [3:0]  word_addr_b;
  logic [15:0] word_data_b;
  logic        word_valid_b;
  logic        read_data_b;
  logic        read_gate_b;
  logic        busy_b;
  logic        underrun_b;

  int n_vectors;
  int n_miscompares;

  int          mem_cnt;
  logic [10:0] mem_addr;
  logic        withhold_on;
  logic [10:0] withhold_addr;

  logic        cap_gate [0:CAP_N];
  logic        cap_data [0:CAP_N];
  logic        cap_busy [0:CAP_N];
  logic        cap_req  [0:CAP_N];
  logic        cap_unr  [0:CAP_N];
  logic [10:0] cap_addr [0:CAP_N];

  sector_serializer u_dut_a (
    .i_clk2_5        (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_sector_strobe (strobe),
    .i_sector        (sector),
    .o_word_req      (word_req),
    .o_word_addr     (word_addr),
    .i_word_data     (word_data),
    .i_word_valid    (word_valid),
    .o_read_data     (read_data),
    .o_read_gate     (read_gate),
    .o_busy          (busy),
    .o_underrun      (underrun)
  );

  sector_serializer #(
    .DATA_WORDS     (1),
    .GAP_BITS       (4),
    .PREAMBLE_BITS  (8),
    .POSTAMBLE_BITS (4)
  ) u_dut_b (
    .i_clk2_5        (clk),
    .i_rst           (rst),
    .i_en            (en_b),
    .i_sector_strobe (strobe_b),
    .i_sector        (sector_b),
    .o_word_req      (word_req_b),
    .o_word_addr     (word_addr_b),
    .i_word_data     (word_data_b),
    .i_word_valid    (word_valid_b),
    .o_read_data     (read_data_b),
    .o_read_gate     (read_gate_b),
    .o_busy          (busy_b),
    .o_underrun      (underrun_b)
  );

  // Free-running bit clock.
  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // Advance to the next falling edge, then play the memory for instance A:
  // word_data = address, word_valid two cycles after the request.
  task automatic step();
    @(negedge clk);
    word_valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        word_valid = 1'b1;
        word_data  = {5'b0, mem_addr};
      end
    end
    if (word_req && !(withhold_on && word_addr == withhold_addr)) begin
      mem_cnt  = 2;
      mem_addr = word_addr;
    end
  endtask

  // Produce a falling strobe on instance A; the following step is cycle E+1.
  task automatic launch_a(input logic [4:0] sec);
    sector = sec;
    strobe = 1'b1;
    step();
    step();
    step();
    strobe = 1'b0;
  endtask

  // Record instance A outputs for cycles E+1 .. E+CAP_N.
  task automatic capture_a();
    for (int n = 1; n <= CAP_N; n++) begin
      step();
      cap_gate[n] = read_gate;
      cap_data[n] = read_data;
      cap_busy[n] = busy;
      cap_req[n]  = word_req;
      cap_unr[n]  = underrun;
      cap_addr[n] = word_addr;
    end
  endtask

  function automatic logic [15:0] word_at(input int start);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], cap_data[start + i]};
    return w;
  endfunction

  function automatic int busy_fall();
    for (int n = 1; n <= CAP_N; n++) if (!cap_busy[n]) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_vectors++;
    if ({word_req, word_addr, read_data, read_gate, busy, underrun} !== 16'h0000) begin
      $display("[TB] FAIL reset_outputs: got %h required 0000",
               {word_req, word_addr, read_data, read_gate, busy, underrun});
      n_miscompares++;
    end
    rst = 1'b0;
    step();
    step();
    n_vectors++;
    if (busy !== 1'b0 || word_req !== 1'b0) begin
      $display("[TB] FAIL reset_release_idle: busy=%b req=%b required 0 0", busy, word_req);
      n_miscompares++;
    end
  endtask

  task automatic test_frame_defaults();
    int bad;
    int gates;
    int last_gate;
    int reqs;
    launch_a(5'd0);
    capture_a();
    n_vectors++;
    if (cap_req[1] !== 1'b1 || cap_addr[1] !== 11'd0) begin
      $display("[TB] FAIL first_req: req=%b addr=%0d required 1 0", cap_req[1], cap_addr[1]);
      n_miscompares++;
    end
    n_vectors++;
    if (cap_busy[1] !== 1'b1) begin
      $display("[TB] FAIL busy_rise: got %b required 1", cap_busy[1]);
      n_miscompares++;
    end
    n_vectors++;
    if (cap_gate[40] !== 1'b0 || cap_gate[41] !== 1'b1) begin
      $display("[TB] FAIL gate_rise: E+40=%b E+41=%b required 0 1", cap_gate[40], cap_gate[41]);
      n_miscompares++;
    end
    n_vectors++;
    if (cap_data[296] !== 1'b0 || cap_data[297] !== 1'b1) begin
      $display("[TB] FAIL sync_bit: E+296=%b E+297=%b required 0 1", cap_data[296], cap_data[297]);
      n_miscompares++;
    end
    n_vectors++;
    if (word_at(298) !== 16'h0000) begin
      $display("[TB] FAIL word0: got %h required 0000", word_at(298));
      n_miscompares++;
    end
    n_vectors++;
    if (word_at(314) !== 16'h0001) begin
      $display("[TB] FAIL word1: got %h required 0001", word_at(314));
      n_miscompares++;
    end
    bad = 0;
    for (int k = 0; k < 128; k++) if (word_at(298 + 16 * k) !== 16'(k)) bad++;
    n_vectors++;
    if (bad !== 0) begin
      $display("[TB] FAIL all_words: %0d wrong words, required 0", bad);
      n_miscompares++;
    end
    gates = 0;
    last_gate = 0;
    reqs = 0;
    for (int n = 1; n <= CAP_N; n++) begin
      if (cap_gate[n]) begin
        gates++;
        last_gate = n;
      end
      if (cap_req[n]) reqs++;
    end
    n_vectors++;
    if (gates !== 257 + 2048 + CRC_BITS || last_gate !== 40 + 257 + 2048 + CRC_BITS) begin
      $display("[TB] FAIL gate_span: count=%0d last=%0d required %0d %0d",
               gates, last_gate, 257 + 2048 + CRC_BITS, 40 + 257 + 2048 + CRC_BITS);
      n_miscompares++;
    end
    n_vectors++;
    if (reqs !== 128) begin
      $display("[TB] FAIL req_count: got %0d required 128", reqs);
      n_miscompares++;
    end
    n_vectors++;
    if (busy_fall() !== FRAME_A + 1) begin
      $display("[TB] FAIL busy_fall: got E+%0d required E+%0d", busy_fall(), FRAME_A + 1);
      n_miscompares++;
    end
    n_vectors++;
    if (underrun !== 1'b0) begin
      $display("[TB] FAIL no_underrun: got %b required 0", underrun);
      n_miscompares++;
    end
  endtask

  task automatic test_underrun();
    withhold_on   = 1'b1;
    withhold_addr = {4'd2, 7'd5};
    launch_a(5'd2);
    capture_a();
    withhold_on = 1'b0;
    n_vectors++;
    if (cap_unr[362] !== 1'b0 || cap_unr[378] !== 1'b1) begin
      $display("[TB] FAIL underrun_timing: word4=%b word5=%b required 0 1", cap_unr[362], cap_unr[378]);
      n_miscompares++;
    end
    n_vectors++;
    if (word_at(298 + 16 * 4) !== 16'd260) begin
      $display("[TB] FAIL underrun_word4: got %h required %h", word_at(298 + 64), 16'd260);
      n_miscompares++;
    end
    n_vectors++;
    if (word_at(298 + 16 * 5) !== 16'h0000) begin
      $display("[TB] FAIL underrun_word5: got %h required 0000", word_at(298 + 80));
      n_miscompares++;
    end
    n_vectors++;
    if (word_at(298 + 16 * 6) !== 16'd262) begin
      $display("[TB] FAIL underrun_word6: got %h required %h", word_at(298 + 96), 16'd262);
      n_miscompares++;
    end
    n_vectors++;
    if (busy_fall() !== FRAME_A + 1 || underrun !== 1'b1) begin
      $display("[TB] FAIL underrun_complete: fall=E+%0d flag=%b required E+%0d 1",
               busy_fall(), underrun, FRAME_A + 1);
      n_miscompares++;
    end
  endtask

  task automatic test_reset_mid_data();
    int seen;
    launch_a(5'd1);
    for (int n = 1; n <= 500; n++) step();
    rst = 1'b1;
    #1;
    n_vectors++;
    if ({word_req, word_addr, read_data, read_gate, busy, underrun} !== 16'h0000) begin
      $display("[TB] FAIL reset_mid_data: got %h required 0000",
               {word_req, word_addr, read_data, read_gate, busy, underrun});
      n_miscompares++;
    end
    mem_cnt = 0;
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (busy || word_req || read_gate) seen++;
    end
    n_vectors++;
    if (seen !== 0) begin
      $display("[TB] FAIL reset_stays_idle: %0d active cycles, required 0", seen);
      n_miscompares++;
    end
  endtask

  task automatic test_abort();
    launch_a(5'd3);
    for (int n = 1; n <= 400; n++) step();
    strobe = 1'b1;
    step();
    n_vectors++;
    if ({busy, read_gate, read_data, word_req} !== 4'b0000) begin
      $display("[TB] FAIL abort_idle: busy/gate/data/req=%b required 0000",
               {busy, read_gate, read_data, word_req});
      n_miscompares++;
    end
    step();
    step();
    n_vectors++;
    if (underrun !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL abort_no_flag: underrun=%b busy=%b required 0 0", underrun, busy);
      n_miscompares++;
    end
    sector = 5'd5;
    strobe = 1'b0;
    step();
    n_vectors++;
    if (word_req !== 1'b1 || word_addr[10:7] !== 4'd5 || word_addr[6:0] !== 7'd0 || busy !== 1'b1) begin
      $display("[TB] FAIL relaunch: req=%b addr=%h busy=%b required 1 %h 1",
               word_req, word_addr, busy, {4'd5, 7'd0});
      n_miscompares++;
    end
  endtask

  task automatic test_en_low();
    int reqs;
    int busys;
    en = 1'b0;
    step();
    step();
    strobe = 1'b1;
    step();
    step();
    step();
    strobe = 1'b0;
    reqs  = 0;
    busys = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (word_req) reqs++;
      if (busy) busys++;
    end
    n_vectors++;
    if (reqs !== 0) begin
      $display("[TB] FAIL en_low_req: %0d pulses, required 0", reqs);
      n_miscompares++;
    end
    n_vectors++;
    if (busys !== 0) begin
      $display("[TB] FAIL en_low_busy: %0d busy cycles, required 0", busys);
      n_miscompares++;
    end
    en = 1'b1;
  endtask

  task automatic test_crc_small();
    logic gb [0:60];
    logic db [0:60];
    logic bb [0:60];
    logic rb [0:60];
    logic [15:0] w;
    int cnt;
    int fall;
    cnt = 0;
    strobe_b = 1'b1;
    step();
    step();
    step();
    strobe_b = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      gb[n] = read_gate_b;
      db[n] = read_data_b;
      bb[n] = busy_b;
      rb[n] = word_req_b;
      word_valid_b = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          word_valid_b = 1'b1;
          word_data_b  = 16'h0001;
        end
      end
      if (word_req_b) cnt = 2;
    end
    n_vectors++;
    if (rb[1] !== 1'b1 || gb[4] !== 1'b0 || gb[5] !== 1'b1 || db[13] !== 1'b1) begin
      $display("[TB] FAIL small_head: req=%b gate4=%b gate5=%b sync=%b required 1 0 1 1",
               rb[1], gb[4], gb[5], db[13]);
      n_miscompares++;
    end
    w = '0;
    for (int i = 14; i < 30; i++) w = {w[14:0], db[i]};
    n_vectors++;
    if (w !== 16'h0001) begin
      $display("[TB] FAIL small_word: got %h required 0001", w);
      n_miscompares++;
    end
`ifdef SECTOR_SERIALIZER_CRC_EN
    w = '0;
    for (int i = 30; i < 46; i++) w = {w[14:0], db[i]};
    n_vectors++;
    if (w !== 16'h1021 || gb[45] !== 1'b1 || gb[46] !== 1'b0) begin
      $display("[TB] FAIL small_crc: got %h gate45=%b gate46=%b required 1021 1 0", w, gb[45], gb[46]);
      n_miscompares++;
    end
`else
    n_vectors++;
    if (gb[29] !== 1'b1 || gb[30] !== 1'b0 || db[30] !== 1'b0) begin
      $display("[TB] FAIL small_no_crc: gate29=%b gate30=%b data30=%b required 1 0 0", gb[29], gb[30], db[30]);
      n_miscompares++;
    end
`endif
    fall = -1;
    for (int n = 60; n >= 1; n--) if (!bb[n] && bb[n-1]) fall = n;
    n_vectors++;
    if (fall !== FRAME_B + 1 || underrun_b !== 1'b0) begin
      $display("[TB] FAIL small_busy_fall: got %0d underrun=%b required %0d 0", fall, underrun_b, FRAME_B + 1);
      n_miscompares++;
    end
  endtask

  // Test sequence.
  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst           = 1'b1;
    en            = 1'b1;
    strobe        = 1'b0;
    sector        = '0;
    word_data     = '0;
    word_valid    = 1'b0;
    en_b          = 1'b1;
    strobe_b      = 1'b0;
    sector_b      = 5'd0;
    word_data_b   = '0;
    word_valid_b  = 1'b0;
    mem_cnt       = 0;
    mem_addr      = '0;
    withhold_on   = 1'b0;
    withhold_addr = '0;
    test_reset();
    test_frame_defaults();
    test_underrun();
    test_reset_mid_data();
    test_abort();
    test_en_low();
    test_crc_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
